// File: rtl/i2c_slave_resp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2c_slave_resp
// Brief    : I2C slave with an 8-entry register file and an auto-increment pointer.
// Revision : 1.0
// ============================================================================
module i2c_slave_resp #(
    parameter logic [6:0] SLV_ADDR = 7'h50,
    parameter logic [7:0] RST_VAL  = 8'h00
) (
    input  logic       wb_clk_i,
    input  logic       arst_i,
    input  logic       scl_pad_i,
    input  logic       sda_pad_i,
    output logic       sda_pad_o,
    output logic       sda_padoen_o,
    input  logic [2:0] reg_adr_i,
    output logic [7:0] reg_dat_o,
    output logic       wr_stb_o,
    output logic [2:0] wr_adr_o,
    output logic       busy_o
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_ADDR_ACK  = 4'd2,
        S_PTR       = 4'd3,
        S_PTR_ACK   = 4'd4,
        S_WDATA     = 4'd5,
        S_WDATA_ACK = 4'd6,
        S_RDATA     = 4'd7,
        S_RACK_CHK  = 4'd8
    } state_t;

    localparam logic [3:0] c_BYTE_BITS = 4'd8;

    logic       r_scl_meta, r_scl_sync, r_scl_prev;
    logic       r_sda_meta, r_sda_sync, r_sda_prev;
    state_t     r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic [2:0] r_ptr, w_ptr_nxt;
    logic       r_oen, w_oen_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_wr_stb;
    logic [2:0] r_wr_adr;
    logic       w_wr_en;
    logic [7:0] r_regs [8];

    logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_byte_done;
    logic [2:0] w_ptr_inc;
    logic [7:0] w_cur_byte, w_next_byte;

    assign w_scl_rise  = r_scl_sync & ~r_scl_prev;
    assign w_scl_fall  = ~r_scl_sync & r_scl_prev;
    assign w_start     = r_scl_sync & r_scl_prev & r_sda_prev & ~r_sda_sync;
    assign w_stop      = r_scl_sync & r_scl_prev & ~r_sda_prev & r_sda_sync;
    assign w_byte_done = w_scl_fall && (r_cnt == c_BYTE_BITS);
    assign w_ptr_inc   = r_ptr + 3'd1;
    assign w_cur_byte  = r_regs[r_ptr];
    assign w_next_byte = r_regs[w_ptr_inc];

    assign sda_pad_o    = 1'b0;
    assign sda_padoen_o = r_oen;
    assign reg_dat_o    = r_regs[reg_adr_i];
    assign wr_stb_o     = r_wr_stb;
    assign wr_adr_o     = r_wr_adr;
    assign busy_o       = r_busy;

    // Lines idle high, so the synchronizer resets to 1 to avoid false START/STOP.
    always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_meta <= scl_pad_i;
            r_scl_sync <= r_scl_meta;
            r_scl_prev <= r_scl_sync;
            r_sda_meta <= sda_pad_i;
            r_sda_sync <= r_sda_meta;
            r_sda_prev <= r_sda_sync;
        end
    end

    always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_ptr    <= '0;
            r_oen    <= 1'b1;
            r_busy   <= 1'b0;
            r_wr_stb <= 1'b0;
            r_wr_adr <= '0;
            for (int i = 0; i < 8; i++) r_regs[i] <= RST_VAL;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shift  <= w_shift_nxt;
            r_ptr    <= w_ptr_nxt;
            r_oen    <= w_oen_nxt;
            r_busy   <= w_busy_nxt;
            r_wr_stb <= w_wr_en;
            if (w_wr_en) begin
                r_wr_adr       <= r_ptr;
                r_regs[r_ptr]  <= r_shift;
            end
        end
    end

    // SDA drive changes happen only on SCL falling edges; START/STOP only release it.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_ptr_nxt   = r_ptr;
        w_oen_nxt   = r_oen;
        w_busy_nxt  = r_busy;
        w_wr_en     = 1'b0;
        if (w_stop) begin
            w_state_nxt = S_IDLE;
            w_oen_nxt   = 1'b1;
            w_busy_nxt  = 1'b0;
        end else if (w_start) begin
            w_state_nxt = S_ADDR;
            w_cnt_nxt   = '0;
            w_oen_nxt   = 1'b1;
        end else begin
            if ((r_state == S_ADDR || r_state == S_PTR || r_state == S_WDATA) &&
                w_scl_rise && (r_cnt != c_BYTE_BITS)) begin
                w_shift_nxt = {r_shift[6:0], r_sda_sync};
                w_cnt_nxt   = r_cnt + 4'd1;
            end
            case (r_state)
                S_IDLE: ;
                S_ADDR: begin
                    if (w_byte_done) begin
                        w_cnt_nxt = '0;
                        if (r_shift[7:1] == SLV_ADDR) begin
                            w_state_nxt = S_ADDR_ACK;
                            w_oen_nxt   = 1'b0;
                            w_busy_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (r_shift[0]) begin
                            w_state_nxt = S_RDATA;
                            w_shift_nxt = w_cur_byte;
                            w_oen_nxt   = w_cur_byte[7];
                            w_cnt_nxt   = 4'd1;
                        end else begin
                            w_state_nxt = S_PTR;
                            w_oen_nxt   = 1'b1;
                            w_cnt_nxt   = '0;
                        end
                    end
                end
                S_PTR: begin
                    if (w_byte_done) begin
                        w_ptr_nxt   = r_shift[2:0];
                        w_state_nxt = S_PTR_ACK;
                        w_oen_nxt   = 1'b0;
                        w_cnt_nxt   = '0;
                    end
                end
                S_PTR_ACK: begin
                    if (w_scl_fall) begin
                        w_state_nxt = S_WDATA;
                        w_oen_nxt   = 1'b1;
                    end
                end
                S_WDATA: begin
                    if (w_byte_done) begin
                        w_wr_en     = 1'b1;
                        w_state_nxt = S_WDATA_ACK;
                        w_oen_nxt   = 1'b0;
                        w_cnt_nxt   = '0;
                    end
                end
                S_WDATA_ACK: begin
                    if (w_scl_fall) begin
                        w_ptr_nxt   = w_ptr_inc;
                        w_state_nxt = S_WDATA;
                        w_oen_nxt   = 1'b1;
                    end
                end
                S_RDATA: begin
                    if (w_scl_fall) begin
                        if (r_cnt == c_BYTE_BITS) begin
                            w_state_nxt = S_RACK_CHK;
                            w_oen_nxt   = 1'b1;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_shift_nxt = {r_shift[6:0], 1'b0};
                            w_oen_nxt   = r_shift[6];
                            w_cnt_nxt   = r_cnt + 4'd1;
                        end
                    end
                end
                S_RACK_CHK: begin
                    // Master ACK/NACK is parked in shift[0] until the closing SCL fall.
                    if (w_scl_rise) begin
                        w_shift_nxt = {7'd0, r_sda_sync};
                    end else if (w_scl_fall) begin
                        if (!r_shift[0]) begin
                            w_ptr_nxt   = w_ptr_inc;
                            w_shift_nxt = w_next_byte;
                            w_oen_nxt   = w_next_byte[7];
                            w_cnt_nxt   = 4'd1;
                            w_state_nxt = S_RDATA;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_oen_nxt   = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_oen_nxt   = 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_resp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave_resp
// Brief    : Bit-banged I2C master with scoreboard checking of ACKs, reads and writes.
// Revision : 1.0
// ============================================================================
module tb_i2c_slave_resp;

    localparam int c_Q = 10;

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       arst;
    logic       scl_m, sda_m;
    logic [2:0] reg_adr;
    wire  logic sda_line;
    logic       sda_pad_o, sda_padoen_o, wr_stb_o, busy_o;
    logic [7:0] reg_dat_o;
    logic [2:0] wr_adr_o;

    logic       resp_valid;
    logic [7:0] resp_data;
    logic       watch;
    int         viol;
    int         checks   = 0;
    int         failures = 0;

    exp_t       resp_q[$];
    logic [2:0] wr_q[$];

    always #5 clk = ~clk;

    assign sda_line = sda_m & (sda_padoen_o | sda_pad_o);

    i2c_slave_resp dut (
        .wb_clk_i     (clk),
        .arst_i       (arst),
        .scl_pad_i    (scl_m),
        .sda_pad_i    (sda_line),
        .sda_pad_o    (sda_pad_o),
        .sda_padoen_o (sda_padoen_o),
        .reg_adr_i    (reg_adr),
        .reg_dat_o    (reg_dat_o),
        .wr_stb_o     (wr_stb_o),
        .wr_adr_o     (wr_adr_o),
        .busy_o       (busy_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write-strobe monitor: every strobe cycle consumes one expected address.
    always @(negedge clk) begin
        if (wr_stb_o === 1'b1) begin
            if (wr_q.size() == 0) chk("wr_stb_unexpected", 32'(wr_stb_o), 32'd0);
            else chk("wr_adr", 32'(wr_adr_o), 32'(wr_q.pop_front()));
        end
    end

    always @(negedge clk) begin : resp_mon
        exp_t e;
        if (resp_valid) begin
            if (resp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL resp_unexpected: got %0h expected none", resp_data);
            end else begin
                e = resp_q.pop_front();
                chk(e.name, 32'(resp_data), 32'(e.val));
            end
        end
    end

    always @(negedge clk) begin
        if (watch && (sda_padoen_o !== 1'b1 || busy_o !== 1'b0)) viol++;
    end

    task automatic quarter();
        repeat (c_Q) @(posedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; quarter();
        scl_m = 1'b1; quarter();
        sda_m = 1'b0; quarter();
        scl_m = 1'b0; quarter();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; quarter();
        scl_m = 1'b1; quarter();
        sda_m = 1'b1; quarter();
    endtask

    task automatic put_bit(input logic b);
        sda_m = b;    quarter();
        scl_m = 1'b1; quarter(); quarter();
        scl_m = 1'b0; quarter();
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; quarter();
        scl_m = 1'b1; quarter();
        b = sda_line; quarter();
        scl_m = 1'b0; quarter();
    endtask

    task automatic emit(input logic [7:0] v);
        resp_data  = v;
        resp_valid = 1'b1;
        @(posedge clk);
        resp_valid = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] d, input logic exp_ack);
        exp_t e;
        logic a;
        e.name = "ack";
        e.val  = {7'd0, exp_ack};
        resp_q.push_back(e);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(a);
        emit({7'd0, a});
    endtask

    task automatic rd_byte(input logic [7:0] exp, input logic mack);
        exp_t e;
        logic [7:0] d;
        logic b;
        e.name = "rdata";
        e.val  = exp;
        resp_q.push_back(e);
        d = '0;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        emit(d);
        put_bit(mack);
    endtask

    task automatic chk_reg(input logic [2:0] a, input logic [7:0] v);
        reg_adr = a;
        #1;
        chk($sformatf("reg%0d", a), 32'(reg_dat_o), 32'(v));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic       b;
        logic [3:0] nib;
        arst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; reg_adr = '0;
        resp_valid = 1'b0; resp_data = '0; watch = 1'b0; viol = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_oen",    32'(sda_padoen_o), 32'd1);
        chk("rst_pad_o",  32'(sda_pad_o),    32'd0);
        chk("rst_wr_stb", 32'(wr_stb_o),     32'd0);
        chk("rst_wr_adr", 32'(wr_adr_o),     32'd0);
        chk("rst_busy",   32'(busy_o),       32'd0);
        chk_reg(3'd5, 8'h00);
        @(negedge clk) arst = 1'b0;
        quarter();

        // Write 0x5A, 0xC3 starting at register 3
        wr_q.push_back(3'd3);
        wr_q.push_back(3'd4);
        bus_start();
        wr_byte(8'hA0, 1'b0);
        chk("busy_in_xfer", 32'(busy_o), 32'd1);
        wr_byte(8'h03, 1'b0);
        wr_byte(8'h5A, 1'b0);
        wr_byte(8'hC3, 1'b0);
        bus_stop();
        quarter();
        chk("busy_after_stop", 32'(busy_o), 32'd0);
        chk_reg(3'd3, 8'h5A);
        chk_reg(3'd4, 8'hC3);

        // Pointer set, repeated START, two-byte read ending in NACK
        bus_start();
        wr_byte(8'hA0, 1'b0);
        wr_byte(8'h03, 1'b0);
        bus_start();
        wr_byte(8'hA1, 1'b0);
        rd_byte(8'h5A, 1'b0);
        rd_byte(8'hC3, 1'b1);
        quarter();
        chk("oen_after_nack", 32'(sda_padoen_o), 32'd1);
        bus_stop();

        // Pointer wraps 7 -> 0 on write auto-increment
        wr_q.push_back(3'd7);
        wr_q.push_back(3'd0);
        bus_start();
        wr_byte(8'hA0, 1'b0);
        wr_byte(8'h07, 1'b0);
        wr_byte(8'h11, 1'b0);
        wr_byte(8'h22, 1'b0);
        bus_stop();
        quarter();
        chk_reg(3'd7, 8'h11);
        chk_reg(3'd0, 8'h22);

        // Pointer survives STOP: read without a pointer phase
        bus_start();
        wr_byte(8'hA0, 1'b0);
        wr_byte(8'h04, 1'b0);
        bus_stop();
        bus_start();
        wr_byte(8'hA1, 1'b0);
        rd_byte(8'hC3, 1'b1);
        bus_stop();

        // Address mismatch: slave stays silent and idle
        viol  = 0;
        watch = 1'b1;
        bus_start();
        wr_byte(8'hA2, 1'b1);
        bus_stop();
        quarter();
        watch = 1'b0;
        chk("mismatch_quiet", 32'(viol), 32'd0);

        // Reset during bit 4 of a read of 0xC3 (bit 4 drives low)
        bus_start();
        wr_byte(8'hA1, 1'b0);
        nib = '0;
        for (int i = 3; i >= 0; i--) begin
            get_bit(b);
            nib[i] = b;
        end
        chk("rd_nibble", 32'(nib), 32'hC);
        sda_m = 1'b1;
        quarter();
        chk("oen_bit4_drive", 32'(sda_padoen_o), 32'd0);
        scl_m = 1'b1;
        quarter();
        @(negedge clk) arst = 1'b1;
        #1;
        chk("oen_async_release", 32'(sda_padoen_o), 32'd1);
        repeat (3) @(negedge clk);
        arst  = 1'b0;
        viol  = 0;
        watch = 1'b1;
        quarter();
        scl_m = 1'b0;
        quarter();
        for (int i = 0; i < 4; i++) get_bit(b);
        bus_stop();
        quarter();
        watch = 1'b0;
        chk("post_reset_quiet", 32'(viol), 32'd0);
        chk_reg(3'd3, 8'h00);
        bus_start();
        wr_byte(8'hA1, 1'b0);
        rd_byte(8'h00, 1'b1);
        bus_stop();
        quarter();

        chk("wr_q_drained",   32'(wr_q.size()),   32'd0);
        chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
